// File: rtl/sobel_gxgy_sched.sv
// sobel_gxgy_sched: shares one gradient kernel between the straight (X) and
// transposed (Y) orientation of each accepted 3x3 window, then pairs the two
// kernel results into gx, gy and a magnitude.
// Optional build macro: SOBEL_MAG_SAT_EN clamps out_mag to MAG_MAX.
module sobel_gxgy_sched #(
    parameter int KLAT    = 2,
    parameter int MAG_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic [7:0]  in11, in12, in13,
    input  logic [7:0]  in21, in22, in23,
    input  logic [7:0]  in31, in32, in33,
    output logic [7:0]  k11, k12, k13,
    output logic [7:0]  k21, k22, k23,
    output logic [7:0]  k31, k32, k33,
    output logic        k_ce,
    input  logic [8:0]  k_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_gx,
    output logic [8:0]  out_gy,
    output logic [9:0]  out_mag,
    output logic        out_sof,
    output logic        out_eol,
    output logic [15:0] pix_count
);

    typedef enum logic {IDLE, ISSUE_Y} state_t;

    typedef struct packed {
        logic v;
        logic y;
        logic sof;
        logic eol;
    } tag_t;

    localparam logic [9:0] MAG_MAX_W = 10'(MAG_MAX);

    state_t            state;
    logic [8:0][7:0]   in_win;
    logic [8:0][7:0]   hold_win;
    logic [8:0][7:0]   tr_win;
    logic [8:0][7:0]   k_win;
    logic              hold_sof;
    logic              hold_eol;
    tag_t              k_tag;
    tag_t [KLAT-1:0]   tag_pipe;
    tag_t              tail;
    logic [8:0]        gx_hold;
    logic [9:0]        mag_sum;
    logic [9:0]        mag_next;

    // Window element index is row*3+col (in11 -> 0, in33 -> 8)
    assign in_win[0] = in11;
    assign in_win[1] = in12;
    assign in_win[2] = in13;
    assign in_win[3] = in21;
    assign in_win[4] = in22;
    assign in_win[5] = in23;
    assign in_win[6] = in31;
    assign in_win[7] = in32;
    assign in_win[8] = in33;

    assign k11 = k_win[0];
    assign k12 = k_win[1];
    assign k13 = k_win[2];
    assign k21 = k_win[3];
    assign k22 = k_win[4];
    assign k23 = k_win[5];
    assign k31 = k_win[6];
    assign k32 = k_win[7];
    assign k33 = k_win[8];

    // Transposed view of the latched window: element (r,c) takes (c,r)
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_transpose
            assign tr_win[gi] = hold_win[(gi % 3) * 3 + (gi / 3)];
        end
    endgenerate

    // Everything upstream of the output register freezes while a result waits
    assign k_ce     = !(out_valid && !out_ready);
    assign in_ready = (state == IDLE) && k_ce;
    assign tail     = tag_pipe[KLAT-1];

    assign mag_sum = {1'b0, gx_hold} + {1'b0, k_out};
`ifdef SOBEL_MAG_SAT_EN
    assign mag_next = (mag_sum > MAG_MAX_W) ? MAG_MAX_W : mag_sum;
`else
    logic [9:0] mag_max_unused;
    assign mag_max_unused = MAG_MAX_W;
    assign mag_next       = mag_sum;
`endif

    // Issue FSM: straight window on accept, transposed copy on the next enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k_win    <= '0;
            hold_win <= '0;
            hold_sof <= 1'b0;
            hold_eol <= 1'b0;
            k_tag    <= '0;
        end else if (k_ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        k_win    <= in_win;
                        hold_win <= in_win;
                        hold_sof <= in_sof;
                        hold_eol <= in_eol;
                        k_tag    <= '{v: 1'b1, y: 1'b0, sof: in_sof, eol: in_eol};
                        state    <= ISSUE_Y;
                    end else begin
                        k_tag <= '0;
                    end
                end
                ISSUE_Y: begin
                    k_win <= tr_win;
                    k_tag <= '{v: 1'b1, y: 1'b1, sof: hold_sof, eol: hold_eol};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipe tracks the kernel's own latency so the tail lines up with k_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else if (k_ce) begin
            tag_pipe[0] <= k_tag;
            for (int i = 1; i < KLAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Pair X and Y kernel results; a reload in the handshake cycle keeps out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_hold   <= '0;
            out_valid <= 1'b0;
            out_gx    <= '0;
            out_gy    <= '0;
            out_mag   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            pix_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                pix_count <= pix_count + 16'd1;
            end
            if (k_ce && tail.v && !tail.y) begin
                gx_hold <= k_out;
            end
            if (k_ce && tail.v && tail.y) begin
                out_gx    <= gx_hold;
                out_gy    <= k_out;
                out_mag   <= mag_next;
                out_sof   <= tail.sof;
                out_eol   <= tail.eol;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gxgy_sched.sv
// Bench for sobel_gxgy_sched: kernel emulated as a KLAT-stage enabled pipeline
// computing k12+k13, so the X result is in12+in13 and the Y result in21+in31.
module tb_sobel_gxgy_sched;

    localparam int KLAT = 2;

    typedef struct {
        logic [8:0] gx;
        logic [8:0] gy;
        logic [9:0] mag;
        logic       sof;
        logic       eol;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic        in_eol;
    logic [7:0]  w [9];
    logic [7:0]  k11, k12, k13, k21, k22, k23, k31, k32, k33;
    logic        k_ce;
    logic [8:0]  k_out;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_gx;
    logic [8:0]  out_gy;
    logic [9:0]  out_mag;
    logic        out_sof;
    logic        out_eol;
    logic [15:0] pix_count;

    logic [8:0]  kpipe [KLAT];
    logic        kmode;
    logic [8:0]  k_direct;

    int          tests = 0;
    int          fails = 0;
    int          delivered = 0;
    bit          auto_push;
    bit          in_acc;
    bit          last_in_ready;
    exp_t        q [$];

    always #5 clk = ~clk;

    sobel_gxgy_sched #(.KLAT(KLAT), .MAG_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_eol(in_eol),
        .in11(w[0]), .in12(w[1]), .in13(w[2]),
        .in21(w[3]), .in22(w[4]), .in23(w[5]),
        .in31(w[6]), .in32(w[7]), .in33(w[8]),
        .k11(k11), .k12(k12), .k13(k13),
        .k21(k21), .k22(k22), .k23(k23),
        .k31(k31), .k32(k32), .k33(k33),
        .k_ce(k_ce), .k_out(k_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag),
        .out_sof(out_sof), .out_eol(out_eol),
        .pix_count(pix_count)
    );

    function automatic logic [8:0] kfun(logic [7:0] a, logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Emulated kernel: KLAT enabled register stages
    always @(posedge clk) begin
        if (k_ce) begin
            kpipe[0] <= kfun(k12, k13);
            for (int i = 1; i < KLAT; i++) kpipe[i] <= kpipe[i-1];
        end
    end
    assign k_out = kmode ? k_direct : kpipe[KLAT-1];

    function automatic logic [9:0] ref_mag(logic [8:0] gx, logic [8:0] gy);
        int s;
        s = int'(gx) + int'(gy);
`ifdef SOBEL_MAG_SAT_EN
        if (s > 255) s = 255;
`endif
        return 10'(s);
    endfunction

    // Expected result for the window currently on the inputs
    function automatic exp_t ref_result();
        exp_t e;
        e.gx  = kfun(w[1], w[2]);   // straight: in12 + in13
        e.gy  = kfun(w[3], w[6]);   // transposed: in21 + in31
        e.mag = ref_mag(e.gx, e.gy);
        e.sof = in_sof;
        e.eol = in_eol;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_window();
        for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
        in_sof = 1'($urandom);
        in_eol = 1'($urandom);
    endtask

    // One clock: sample handshakes mid-cycle, score results, then step past the edge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_in_ready = in_ready;
        in_acc = in_valid && in_ready;
        if (in_acc && auto_push) q.push_back(ref_result());
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_gx", 32'(out_gx), 32'(e.gx));
                chk("sb_gy", 32'(out_gy), 32'(e.gy));
                chk("sb_mag", 32'(out_mag), 32'(e.mag));
                chk("sb_sof", 32'(out_sof), 32'(e.sof));
                chk("sb_eol", 32'(out_eol), 32'(e.eol));
                $display("[TB] result %0d gx=%0d gy=%0d mag=%0d sof=%0b eol=%0b",
                         delivered, out_gx, out_gy, out_mag, out_sof, out_eol);
            end
            delivered++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string tag);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() > 0 || out_valid) && n < 100) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        chk({tag, "_pix_count"}, 32'(pix_count), 32'(delivered & 16'hFFFF));
    endtask

    initial begin
        exp_t        e;
        int          acc;
        int          n;
        bit          prev_rdy;
        logic [71:0] ksnap;
        logic [8:0]  gsnap;
        logic [9:0]  msnap;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        kmode = 1'b0;
        k_direct = 9'h1FF;
        auto_push = 1'b1;
        in_sof = 1'b0;
        in_eol = 1'b0;
        for (int i = 0; i < 9; i++) w[i] = 8'd0;

        // ---- Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pix_count", 32'(pix_count), 32'd0);
        chk("rst_kwin", 32'(|{k11, k12, k13, k21, k22, k23, k31, k32, k33}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- Single window, timed kernel answers 40 (X) then 25 (Y)
        kmode = 1'b1;
        auto_push = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) w[i] = 8'd10;
        in_valid = 1'b1;
        cycle();
        chk("t2_accept", 32'(in_acc), 32'd1);
        e.gx = 9'd40; e.gy = 9'd25; e.mag = 10'd65; e.sof = 1'b0; e.eol = 1'b0;
        q.push_back(e);
        in_valid = 1'b0;
        chk("t2_k_straight", 32'(k22), 32'd10);
        cycle();
        cycle();
        k_direct = 9'd40;
        cycle();
        k_direct = 9'd25;
        chk("t2_not_early", 32'(out_valid), 32'd0);
        cycle();
        k_direct = 9'h1FF;
        chk("t2_valid_at_4", 32'(out_valid), 32'd1);
        chk("t2_gx", 32'(out_gx), 32'd40);
        chk("t2_gy", 32'(out_gy), 32'd25);
        chk("t2_mag", 32'(out_mag), 32'd65);
        cycle();
        chk("t2_cleared", 32'(out_valid), 32'd0);
        kmode = 1'b0;
        auto_push = 1'b1;
        drain("t2");

        // ---- Transpose: only in12 set
        for (int i = 0; i < 9; i++) w[i] = 8'd0;
        w[1] = 8'd1;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t3_x_k12", 32'(k12), 32'd1);
        chk("t3_x_k21", 32'(k21), 32'd0);
        cycle();
        chk("t3_y_k21", 32'(k21), 32'd1);
        chk("t3_y_k12", 32'(k12), 32'd0);
        drain("t3");

        // ---- Mid-stream reset discards everything in flight
        new_window();
        in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (in_acc) new_window();
        end
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_out_gx", 32'(out_gx), 32'd0);
        chk("t1_out_gy", 32'(out_gy), 32'd0);
        chk("t1_out_mag", 32'(out_mag), 32'd0);
        chk("t1_out_side", 32'({out_sof, out_eol}), 32'd0);
        chk("t1_pix_count", 32'(pix_count), 32'd0);
        chk("t1_kwin", 32'(|{k11, k12, k13, k21, k22, k23, k31, k32, k33}), 32'd0);
        in_valid = 1'b0;
        q.delete();
        delivered = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (out_valid) n++;
        end
        chk("t1_no_stale_result", 32'(n), 32'd0);

        // ---- 100 back-to-back windows, no backpressure
        out_ready = 1'b1;
        new_window();
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 400 && acc < 100; c++) begin
            cycle();
            if (c > 0) chk("t4_rdy_toggle", 32'(last_in_ready != prev_rdy), 32'd1);
            prev_rdy = last_in_ready;
            if (in_acc) begin
                acc++;
                if (acc < 100) new_window();
                else in_valid = 1'b0;
            end
        end
        chk("t4_accepted", 32'(acc), 32'd100);
        drain("t4");
        chk("t4_pix_100", 32'(pix_count), 32'd100);

        // ---- Backpressure: hold out_ready low for 10 cycles with work in flight
        out_ready = 1'b0;
        new_window();
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            cycle();
            if (in_acc) new_window();
            n++;
        end
        chk("t5_stall_reached", 32'(out_valid), 32'd1);
        ksnap = {k11, k12, k13, k21, k22, k23, k31, k32, k33};
        gsnap = out_gy;
        msnap = out_mag;
        for (int c = 0; c < 10; c++) begin
            chk("t5_k_ce", 32'(k_ce), 32'd0);
            chk("t5_in_ready", 32'(in_ready), 32'd0);
            chk("t5_out_valid", 32'(out_valid), 32'd1);
            chk("t5_gy_stable", 32'(out_gy), 32'(gsnap));
            chk("t5_mag_stable", 32'(out_mag), 32'(msnap));
            chk("t5_k_stable", 32'({k11, k12, k13, k21, k22, k23, k31, k32, k33} == ksnap), 32'd1);
            cycle();
        end
        for (int c = 0; c < 300; c++) begin
            out_ready = 1'($urandom);
            cycle();
            if (in_acc || !in_valid) begin
                in_valid = 1'($urandom);
                if (in_valid) new_window();
            end
        end
        drain("t5");

        // ---- Wide sum and sideband: gx=300, gy=200
        for (int i = 0; i < 9; i++) w[i] = 8'd0;
        w[1] = 8'd150; w[2] = 8'd150; w[3] = 8'd100; w[6] = 8'd100;
        in_sof = 1'b1;
        in_eol = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_gx", 32'(out_gx), 32'd300);
        chk("t6_gy", 32'(out_gy), 32'd200);
`ifdef SOBEL_MAG_SAT_EN
        chk("t6_mag", 32'(out_mag), 32'd255);
`else
        chk("t6_mag", 32'(out_mag), 32'd500);
`endif
        chk("t6_sof", 32'(out_sof), 32'd1);
        chk("t6_eol", 32'(out_eol), 32'd1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
